// File: rtl/btn_cond_if.sv
// Button bundle between the board pins and the conditioner.
// The master side drives the raw pins. The slave side returns the conditioned level and pulse vectors.
interface btn_cond_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button conditioner: 2-flop synchroniser, counter debounce FSM, level and press/release pulses.
// Optional auto-repeat pulse train is enabled by defining BTN_COND_AUTO_REPEAT_EN.
module btn_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int REPEAT_DELAY    = 19500000,
  parameter int REPEAT_PERIOD   = 3250000
) (
  input  logic       clk,
  input  logic       rst,
  btn_cond_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_COND_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_ZERO    = {REP_W{1'b0}};
  localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HELD      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_conditioner: invalid timing parameters");
  end

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [N_BTN-1:0] level_v_s;
  logic [N_BTN-1:0] press_v_s;
  logic [N_BTN-1:0] release_v_s;
  logic [N_BTN-1:0] repeat_v_s;

  // Two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= {N_BTN{1'b0}};
      sync2_r <= {N_BTN{1'b0}};
    end else begin
      sync1_r <= bus.btn_raw;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             level_r, level_s;
    logic             press_r, press_s;
    logic             release_r, release_s;

    // Debounce state, counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_r   <= IDLE;
        cnt_r     <= CNT_ZERO;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        state_r   <= state_s;
        cnt_r     <= cnt_s;
        level_r   <= level_s;
        press_r   <= press_s;
        release_r <= release_s;
      end
    end

    // Next state: any sample disagreeing with the candidate level restarts qualification
    always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      level_s   = level_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      case (state_r)
        IDLE: begin
          if (sync2_r[i]) begin
            state_s = WAIT_HIGH;
            cnt_s   = CNT_ONE;
          end else begin
            cnt_s   = CNT_ZERO;
          end
        end
        WAIT_HIGH: begin
          if (!sync2_r[i]) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_s = HELD;
            cnt_s   = CNT_ZERO;
            level_s = 1'b1;
            press_s = 1'b1;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync2_r[i]) begin
            state_s = WAIT_LOW;
            cnt_s   = CNT_ONE;
          end else begin
            cnt_s   = CNT_ZERO;
          end
        end
        WAIT_LOW: begin
          if (sync2_r[i]) begin
            state_s   = HELD;
            cnt_s     = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_s   = IDLE;
            cnt_s     = CNT_ZERO;
            level_s   = 1'b0;
            release_s = 1'b1;
          end else begin
            cnt_s     = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          level_s = 1'b0;
        end
      endcase
    end

    assign level_v_s[i]   = level_r;
    assign press_v_s[i]   = press_r;
    assign release_v_s[i] = release_r;

`ifdef BTN_COND_AUTO_REPEAT_EN
    logic [REP_W-1:0] rep_cnt_r, rep_cnt_s;
    logic             rep_armed_r, rep_armed_s;
    logic             repeat_r, repeat_s;

    // Repeat counter and registered repeat pulse
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rep_cnt_r   <= REP_ZERO;
        rep_armed_r <= 1'b0;
        repeat_r    <= 1'b0;
      end else begin
        rep_cnt_r   <= rep_cnt_s;
        rep_armed_r <= rep_armed_s;
        repeat_r    <= repeat_s;
      end
    end

    // First pulse after the delay, then one per period; release clears and wins over repeat
    always_comb begin
      rep_cnt_s   = rep_cnt_r;
      rep_armed_s = rep_armed_r;
      repeat_s    = 1'b0;
      if (press_s || release_s || (state_r == IDLE) || (state_r == WAIT_HIGH)) begin
        rep_cnt_s   = REP_ZERO;
        rep_armed_s = 1'b0;
      end else if (rep_cnt_r == (rep_armed_r ? PERIOD_LAST : DELAY_LAST)) begin
        rep_cnt_s   = REP_ZERO;
        rep_armed_s = 1'b1;
        repeat_s    = 1'b1;
      end else begin
        rep_cnt_s   = rep_cnt_r + REP_ONE;
      end
    end

    assign repeat_v_s[i] = repeat_r;
`else
    assign repeat_v_s[i] = 1'b0;
`endif
  end

  assign bus.btn_level   = level_v_s;
  assign bus.btn_press   = press_v_s;
  assign bus.btn_release = release_v_s;
  assign bus.btn_repeat  = repeat_v_s;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions raw Basys3 push-buttons (btnL, btnR, others as needed) before they reach the game logic in top_vga, in the 65 MHz pixel-clock domain.
- Per button it provides:
  - 2-flop synchronisation,
  - counter-based debounce,
  - a clean level output,
  - single-cycle press and release pulses,
  - an optional auto-repeat pulse train for held buttons (player movement).
- Sits directly upstream of the player/shooter control logic; instantiated between the board pins and top_vga.

Parameters:
- N_BTN, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 650000, consecutive stable synchronised cycles needed to accept a change (10 ms at 65 MHz); must be >= 2.
- REPEAT_DELAY, 19500000, cycles from accepted press to first repeat pulse (300 ms); used only with BTN_COND_AUTO_REPEAT_EN.
- REPEAT_PERIOD, 3250000, cycles between later repeat pulses (50 ms); used only with BTN_COND_AUTO_REPEAT_EN.

Ports:
- clk  input  1  65 MHz system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- btn_raw  input  N_BTN  raw, asynchronous, bouncing button pins; 1 = pressed.
- btn_level  output  N_BTN  debounced level.
- btn_press  output  N_BTN  1-cycle pulse on an accepted 0->1 change.
- btn_release  output  N_BTN  1-cycle pulse on an accepted 1->0 change.
- btn_repeat  output  N_BTN  1-cycle auto-repeat pulse; tied to 0 when the feature is disabled.

Behaviour:

Reset:
- rst=0 asynchronously clears all synchroniser flops, counters, FSM state (IDLE) and every output to 0.
- Release of rst is not internally synchronised; the upstream reset path is responsible for synchronised deassertion.

Synchroniser:
- 2 flops per channel produce s[i].
- Raw-to-s latency is 2 edges.

Debounce FSM (per channel, fully independent):
- States: IDLE (level 0), WAIT_HIGH, HELD (level 1), WAIT_LOW.
- Counter width: $clog2(DEBOUNCE_CYCLES+1).
- IDLE:
  - s=1 -> WAIT_HIGH, cnt=1.
- WAIT_HIGH:
  - s=0 -> IDLE, cnt=0 (glitch rejected, no pulse).
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, level=1, press=1 for exactly one cycle.
  - Otherwise cnt++.
- HELD:
  - s=0 -> WAIT_LOW, cnt=1.
- WAIT_LOW: mirror of WAIT_HIGH.
  - s=1 returns to HELD with no pulse.
  - Completion -> IDLE, level=0, release=1 for one cycle.
- Latency:
  - For a clean step at the raw input, level changes and the pulse fires on the (DEBOUNCE_CYCLES+2)-th rising edge after the raw change.
  - Pulses are registered and coincide with the level change.
- Bounce handling:
  - Any bounce restarts the qualification from scratch.
  - A pulse train shorter than DEBOUNCE_CYCLES produces no output change.
- press and release are never asserted in the same cycle on one channel.
- Separate channels may pulse in the same cycle.
- The counter never wraps: it saturates at the comparison point.

Optional Feature:
- Macro: BTN_COND_AUTO_REPEAT_EN.
- Defined:
  - Per-channel repeat counter, width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - Loaded to 0 on entry to HELD.
  - Emits btn_repeat=1 for one cycle when it reaches REPEAT_DELAY-1, then every REPEAT_PERIOD cycles after that while the channel remains HELD or WAIT_LOW.
  - Cleared on entry to IDLE.
  - Repeat never coincides with press (first repeat is >= REPEAT_DELAY cycles later).
  - A repeat may coincide with release only if the counters align; in that case release wins and repeat is suppressed.
- Undefined:
  - No repeat logic is synthesised.
  - btn_repeat is constant 0.

Test Plan:
Bench parameters for all cases: DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, N_BTN=2.
1. Reset: hold rst=0 with btn_raw=2'b11 -> all outputs 0. Release rst with the input steady -> level[1:0]=2'b11 on edge 10 after release; press=2'b11 for one cycle; no release pulse.
2. Clean press on ch0: raw 0->1 at edge 0 -> btn_level[0]=1 and btn_press[0]=1 at edge 10. btn_press[0]=0 at edge 11. ch1 outputs unchanged.
3. Bounce: raw ch0 toggles 1,0,1,1,0 with 3-cycle spacing, then held 1 -> exactly one press pulse, 10 edges after the final 0->1 step; level never glitches.
4. Short glitch: raw ch1 high for 7 cycles, then low -> no press, no release, btn_level[1] stays 0.
5. Release during held: ch0 held then raw 1->0 -> btn_release[0]=1 for one cycle at edge 10 after the step, and level=0 in the same cycle. A 5-cycle 0-glitch while held produces no pulses.
6. Auto-repeat (macro defined): ch0 held after press at cycle P -> repeat pulses at P+20, P+25, P+30 and onward. Release stops the pulses. With the macro undefined, btn_repeat stays 0 throughout.
